// File: rtl/sseg_pkg.sv
// Seven-segment bus constants shared by the frame capture block and display checkers.
// Segment byte bit order, msb to lsb: AA AB AC AD AE AF AG DP.
package sseg_pkg;

    localparam int SEG_AA = 7;
    localparam int SEG_AB = 6;
    localparam int SEG_AC = 5;
    localparam int SEG_AD = 4;
    localparam int SEG_AE = 3;
    localparam int SEG_AF = 2;
    localparam int SEG_AG = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high glyphs for hex 0..F, DP bit clear.
    localparam logic [7:0] SEG_GLYPH [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

endpackage

// File: rtl/sseg2bin.sv
// Combinational seven-segment glyph decoder: AA..AG pattern to hex nibble.
// Anything that is not one of the 16 hex glyphs (blank included) flags err.
module sseg2bin
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    // Table lookup against the glyph constants; glyphs are unique so at most one hits.
    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_GLYPH[i][SEG_AA:SEG_AG]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_frame_capture.sv
// Receive side of the multiplexed seven-segment bus: synchronizes the scanned
// anode/segment lines, waits for each digit to settle, decodes it and assembles
// a full frame presented on a valid/ready interface.
module sseg_frame_capture
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic [7:0]                seg,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [4*NUM_DIGITS-1:0]   frame_data,
    output logic [NUM_DIGITS-1:0]     frame_dp,
    output logic [NUM_DIGITS-1:0]     frame_err,
    output logic                      overrun
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = NUM_DIGITS + 8;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(SETTLE_CYCLES);
    // Counter value one step before the capture point (counter reaches SETTLE_CYCLES-1).
    localparam logic [CNT_W-1:0]      CNT_PRE  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   an_meta_q, an_sync_q;
    logic [7:0]              seg_meta_q, seg_sync_q;

    logic [NUM_DIGITS-1:0]   an_norm;
    logic [7:0]              seg_norm;
    logic [SMP_W-1:0]        smp_cur;
    logic                    stable;
    logic                    an_onehot;
    logic                    capture;
    logic                    mask_full;
    logic                    out_free;
    logic                    load;
    logic                    handshake;
    logic [3:0]              dec_nibble;
    logic                    dec_err;

    logic [SMP_W-1:0]        smp_prev_q, smp_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] work_data_q, work_data_d;
    logic [NUM_DIGITS-1:0]   work_dp_q, work_dp_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    overrun_q, overrun_d;

    // Two-flop synchronizers for the asynchronous display lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q  <= '0;
            an_sync_q  <= '0;
            seg_meta_q <= '0;
            seg_sync_q <= '0;
        end else begin
            an_meta_q  <= an;
            an_sync_q  <= an_meta_q;
            seg_meta_q <= seg;
            seg_sync_q <= seg_meta_q;
        end
    end

    // Normalize to active-high and classify the current sample.
    always_comb begin
        an_norm   = (AN_ACTIVE_LOW != 0)  ? ~an_sync_q  : an_sync_q;
        seg_norm  = (SEG_ACTIVE_LOW != 0) ? ~seg_sync_q : seg_sync_q;
        smp_cur   = {an_norm, seg_norm};
        stable    = (smp_cur == smp_prev_q);
        an_onehot = (an_norm != '0) && ((an_norm & (an_norm - AN_ONE)) == '0);
    end

    sseg2bin u_dec (
        .pattern (seg_norm[SEG_AA:SEG_AG]),
        .nibble  (dec_nibble),
        .err     (dec_err)
    );

    // Settle counter, working slots, frame output register and overrun flag.
    always_comb begin
        smp_prev_d  = smp_cur;
        cnt_d       = '0;
        mask_d      = mask_q;
        work_data_d = work_data_q;
        work_dp_d   = work_dp_q;
        work_err_d  = work_err_q;
        valid_d     = valid_q;
        data_d      = data_q;
        dp_d        = dp_q;
        err_d       = err_q;
        overrun_d   = overrun_q;

        if (stable) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        // Only the single step into SETTLE_CYCLES-1 captures, so one capture per dwell.
        capture   = stable && (cnt_q == CNT_PRE) && an_onehot;
        mask_full = &mask_q;
        handshake = valid_q && frame_ready;
        out_free  = !valid_q || frame_ready;
        load      = mask_full && out_free;

        // Loading copies the pre-capture slots; a capture on the same edge seeds the next frame.
        if (load) begin
            data_d  = work_data_q;
            dp_d    = work_dp_q;
            err_d   = work_err_q;
            valid_d = 1'b1;
            mask_d  = '0;
        end else if (handshake) begin
            valid_d = 1'b0;
        end

        if (capture) begin
            mask_d = mask_d | an_norm;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an_norm[i]) begin
                    work_data_d[4*i +: 4] = dec_nibble;
                    work_dp_d[i]          = seg_norm[SEG_DP];
                    work_err_d[i]         = dec_err;
                end
            end
        end

        if (capture && mask_full && !out_free) begin
            overrun_d = 1'b1;
        end else if (handshake) begin
            overrun_d = 1'b0;
        end
    end

    // State register for the capture pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_prev_q  <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            work_data_q <= '0;
            work_dp_q   <= '0;
            work_err_q  <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            dp_q        <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            smp_prev_q  <= smp_prev_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            work_data_q <= work_data_d;
            work_dp_q   <= work_dp_d;
            work_err_q  <= work_err_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            dp_q        <= dp_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_valid = valid_q;
    assign frame_data  = data_q;
    assign frame_dp    = dp_q;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sseg_frame_capture.sv
// Directed bench for sseg_frame_capture with default parameters
// (4 digits, settle 16, active-low anodes and segments).
module tb_sseg_frame_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_ready;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_err;
    logic        overrun;

    sseg_frame_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Hand-entered active-high glyphs 0..F.
    logic [7:0] g [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_drive;

    always @(posedge clk) cyc++;

    // Record every accepted frame (valid and ready both high going into an edge).
    int          hs_cnt = 0;
    int          hs_cyc = 0;
    logic [15:0] hs_data = '0;
    logic [3:0]  hs_dp = '0;
    logic [3:0]  hs_err = '0;
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            hs_cnt++;
            hs_cyc  = cyc;
            hs_data = frame_data;
            hs_dp   = frame_dp;
            hs_err  = frame_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [7:0] pat, input int n);
        an  = ~(4'b0001 << k);
        seg = ~pat;
        tick(n);
    endtask

    task automatic idle(input int n);
        an  = 4'hF;
        seg = 8'hFF;
        tick(n);
    endtask

    task automatic scan(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
        show(0, p0, 32);
        show(1, p1, 32);
        show(2, p2, 32);
        show(3, p3, 32);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog no finish got timeout want done");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        an          = 4'hF;
        seg         = 8'hFF;
        frame_ready = 1'b0;
        tick(3);
        chk("reset_outs", {frame_valid, overrun, frame_dp, frame_err, frame_data}, 32'h0);
        #4 rst_n = 1'b1;
        tick(4);

        // Basic scan 3,0,A,7 with ready high; latency from last digit change.
        frame_ready = 1'b1;
        show(0, g[3], 32);
        show(1, g[0], 32);
        show(2, g[10], 32);
        chk("t1_no_frame_3dig", hs_cnt, 0);
        t_drive = cyc;
        show(3, g[7], 32);
        idle(8);
        chk("t1_count", hs_cnt, 1);
        chk("t1_data", hs_data, 16'h7A03);
        chk("t1_dp", hs_dp, 4'h0);
        chk("t1_err", hs_err, 4'h0);
        chk("t1_latency", hs_cyc - t_drive, 19);
        chk("t1_valid_drop", {frame_valid, overrun}, 2'b00);

        // DP on digit 1, illegal pattern 0x02 on digit 2.
        scan(g[3], g[0] | 8'h01, 8'h02, g[7]);
        idle(8);
        chk("t2_count", hs_cnt, 2);
        chk("t2_data", hs_data, 16'h7003);
        chk("t2_dp", hs_dp, 4'b0010);
        chk("t2_err", hs_err, 4'b0100);

        // Short 8-cycle glitch on the last digit must not capture.
        show(0, g[1], 32);
        show(1, g[2], 32);
        show(2, g[3], 32);
        show(3, g[8], 8);
        idle(40);
        chk("t3_glitch_nocap", hs_cnt, 2);
        show(3, g[4], 32);
        idle(8);
        chk("t3_count", hs_cnt, 3);
        chk("t3_data", hs_data, 16'h4321);

        // Two anodes active for a whole dwell must not capture.
        show(0, g[5], 32);
        show(1, g[6], 32);
        show(2, g[9], 32);
        an  = 4'b0011;
        seg = ~g[11];
        tick(32);
        chk("t4_dual_nocap", hs_cnt, 3);
        show(3, g[11], 32);
        idle(8);
        chk("t4_count", hs_cnt, 4);
        chk("t4_data", hs_data, 16'hB965);

        // Back-pressure: hold first frame, newest values win, overrun then clear.
        frame_ready = 1'b0;
        scan(g[12], g[13], g[14], g[15]);
        idle(8);
        chk("t5_held_valid", frame_valid, 1'b1);
        chk("t5_first_data", frame_data, 16'hFEDC);
        chk("t5_no_overrun_yet", overrun, 1'b0);
        scan(g[8], g[9], g[11], g[2]);
        show(3, g[6], 32);
        idle(8);
        chk("t5_hold_data", {frame_valid, frame_err, frame_dp, frame_data}, {1'b1, 4'h0, 4'h0, 16'hFEDC});
        chk("t5_overrun_set", overrun, 1'b1);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        chk("t5_reload_valid", frame_valid, 1'b1);
        chk("t5_newest_data", frame_data, 16'h6B98);
        chk("t5_overrun_clr", overrun, 1'b0);
        chk("t5_hs_first", {hs_cnt[7:0], hs_data}, {8'd5, 16'hFEDC});
        tick(3);
        chk("t5_still_held", {frame_valid, frame_data}, {1'b1, 16'h6B98});
        frame_ready = 1'b1;
        tick(1);
        chk("t5_drained", frame_valid, 1'b0);
        chk("t5_hs_second", {hs_cnt[7:0], hs_data}, {8'd6, 16'h6B98});

        // Asynchronous reset mid-scan discards the partial frame.
        show(0, g[1], 32);
        show(1, g[2], 32);
        an  = ~4'b0100;
        seg = ~g[3];
        tick(5);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {frame_valid, overrun, frame_dp, frame_err, frame_data}, 32'h0);
        tick(3);
        #4 rst_n = 1'b1;
        tick(1);
        show(2, g[3], 32);
        show(3, g[4], 32);
        chk("t6_partial_nofrm", hs_cnt, 6);
        show(0, g[5], 32);
        show(1, g[6], 32);
        idle(8);
        chk("t6_count", hs_cnt, 7);
        chk("t6_data", hs_data, 16'h4365);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
